// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one SPI controller and its command/read FIFOs
// among NUM_REQ requesters: load write words, run the transaction, drain read words.
module spi_txn_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          axi_clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wnr,
    input  logic [NUM_REQ*10-1:0]         req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    input  logic [NUM_REQ*2-1:0]          req_opgrp,
    input  logic [NUM_REQ-1:0]            wdata_valid,
    output logic [NUM_REQ-1:0]            wdata_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic                          rdata_valid,
    input  logic                          rdata_ready,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ID_W-1:0]               rdata_id,
    output logic                          rdata_last,
    output logic                          spi_wnr,
    output logic [9:0]                    spi_address,
    output logic [1:0]                    spi_opcode_group,
    output logic [7:0]                    spi_data_len,
    output logic                          spi_command_wr_en,
    output logic [DATA_WIDTH-1:0]         spi_command_din,
    input  logic                          spi_command_full,
    output logic                          spi_read_rd_en,
    input  logic [DATA_WIDTH-1:0]         spi_read_dout,
    input  logic                          spi_read_empty,
    input  logic                          done,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [1:0]                    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] owner;
    logic [7:0]      len_q;
    logic [7:0]      cnt;
    logic [31:0]     timer;
    logic            pop_pending;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] scan_idx;
    int              scan_j;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_j      = 0;
        scan_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_j = int'(rr_ptr) + i;
            if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
            scan_idx = ID_W'(scan_j);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        wdata_ready = '0;
        if (state == IDLE && !reset && grant_found) req_ready[grant_idx] = 1'b1;
        if (state == LOAD && !spi_command_full) wdata_ready[owner] = 1'b1;
    end

    assign spi_command_wr_en = (state == LOAD) && wdata_valid[owner] && !spi_command_full;
    assign spi_command_din   = spi_command_wr_en ? wdata[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

    // Only one pop in flight: its word lands in the output register the next cycle.
    assign spi_read_rd_en = (state == DRAIN) && !spi_read_empty && !pop_pending &&
                            (cnt != len_q) && (!rdata_valid || rdata_ready);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge axi_clk) begin
        if (reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            owner            <= '0;
            len_q            <= '0;
            cnt              <= '0;
            timer            <= '0;
            pop_pending      <= 1'b0;
            spi_wnr          <= 1'b0;
            spi_address      <= '0;
            spi_opcode_group <= '0;
            spi_data_len     <= '0;
            err_timeout      <= 1'b0;
            rdata            <= '0;
            rdata_valid      <= 1'b0;
            rdata_id         <= '0;
            rdata_last       <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            pop_pending <= spi_read_rd_en;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr           <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
                        owner            <= grant_idx;
                        spi_wnr          <= req_wnr[grant_idx];
                        spi_address      <= req_addr[grant_idx*10 +: 10];
                        spi_opcode_group <= req_opgrp[grant_idx*2 +: 2];
                        len_q            <= req_len[grant_idx*8 +: 8];
                        cnt              <= '0;
                        timer            <= '0;
                        // Zero-length requests are acknowledged without touching the SPI side.
                        if (req_len[grant_idx*8 +: 8] != 8'd0) begin
                            if (req_wnr[grant_idx]) begin
                                state <= LOAD;
                            end else begin
                                state        <= RUN;
                                spi_data_len <= req_len[grant_idx*8 +: 8];
                            end
                        end
                    end
                end
                LOAD: begin
                    if (spi_command_wr_en) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == len_q) begin
                            state        <= RUN;
                            spi_data_len <= len_q;
                            timer        <= '0;
                        end
                    end
                end
                RUN: begin
                    if (done) begin
                        spi_data_len <= '0;
                        cnt          <= '0;
                        state        <= spi_wnr ? IDLE : DRAIN;
                    end else if (timer == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_timeout  <= 1'b1;
                        spi_data_len <= '0;
                        state        <= IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                DRAIN: begin
                    if (rdata_valid && rdata_ready) begin
                        rdata_valid <= 1'b0;
                        if (rdata_last) begin
                            rdata_last <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                    if (pop_pending) begin
                        rdata       <= spi_read_dout;
                        rdata_valid <= 1'b1;
                        rdata_id    <= owner;
                        rdata_last  <= (cnt + 8'd1 == len_q);
                        cnt         <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: write/read flow, contention, backpressure,
// timeout, zero/max length and reset during a transaction.
module tb_spi_txn_arbiter;

  logic        axi_clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_wnr;
  logic [19:0] req_addr;
  logic [15:0] req_len;
  logic [3:0]  req_opgrp;
  logic [1:0]  wdata_valid;
  logic [1:0]  wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic [0:0]  rdata_id;
  logic        rdata_last;
  logic        spi_wnr;
  logic [9:0]  spi_address;
  logic [1:0]  spi_opcode_group;
  logic [7:0]  spi_data_len;
  logic        spi_command_wr_en;
  logic [31:0] spi_command_din;
  logic        spi_command_full;
  logic        spi_read_rd_en;
  logic [31:0] spi_read_dout;
  logic        spi_read_empty;
  logic        done;
  logic        busy;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  spi_txn_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .axi_clk(axi_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wnr(req_wnr),
    .req_addr(req_addr), .req_len(req_len), .req_opgrp(req_opgrp),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_id(rdata_id), .rdata_last(rdata_last),
    .spi_wnr(spi_wnr), .spi_address(spi_address), .spi_opcode_group(spi_opcode_group),
    .spi_data_len(spi_data_len), .spi_command_wr_en(spi_command_wr_en),
    .spi_command_din(spi_command_din), .spi_command_full(spi_command_full),
    .spi_read_rd_en(spi_read_rd_en), .spi_read_dout(spi_read_dout),
    .spi_read_empty(spi_read_empty), .done(done), .busy(busy),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // FIFO models: command pushes are recorded, read FIFO is a preloaded queue
  logic [31:0] cmd_q[$];
  logic [31:0] rd_fifo[$];
  int          pops;

  always @(posedge axi_clk) begin
    if (spi_command_wr_en) cmd_q.push_back(spi_command_din);
    if (spi_read_rd_en && rd_fifo.size() > 0) begin
      spi_read_dout  <= rd_fifo.pop_front();
      pops           = pops + 1;
      spi_read_empty <= (rd_fifo.size() == 0);
    end
  end

  // scoreboard
  int          checks;
  int          errors;
  logic [31:0] exp_q[$];
  logic [31:0] got_d[$];
  logic        got_id[$];
  logic        got_l[$];
  logic        got_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc();
    done = 1'b0;
  endtask

  task automatic preload(input logic [31:0] w);
    rd_fifo.push_back(w);
    spi_read_empty = 1'b0;
  endtask

  task automatic collect(input int budget);
    logic rec;
    got_d.delete();
    got_id.delete();
    got_l.delete();
    got_last = 1'b0;
    for (int c = 0; c < budget; c++) begin
      rec = rdata_valid && rdata_ready;
      if (rec) begin
        got_d.push_back(rdata);
        got_id.push_back(rdata_id[0]);
        got_l.push_back(rdata_last);
      end
      cyc();
      if (rec && got_l[got_l.size()-1]) begin
        got_last = 1'b1;
        break;
      end
    end
    chk("rd_last_seen", got_last, 1'b1);
  endtask

  task automatic check_read(input string tag, input logic exp_id);
    chk({tag, "_count"}, got_d.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_d.size()) begin
        chk({tag, "_data"}, got_d[i], exp_q[i]);
        chk({tag, "_id"}, got_id[i], exp_id);
        chk({tag, "_last"}, got_l[i], (i == exp_q.size() - 1));
      end
    end
  endtask

  int          n0;
  int          p0;
  int          run_cycles;
  logic        seen_err;
  logic [31:0] first_word;
  logic [1:0]  exp_grant;

  initial begin
    checks = 0; errors = 0; pops = 0;
    reset = 1'b1; req_valid = '0; req_wnr = '0; req_addr = '0; req_len = '0;
    req_opgrp = '0; wdata_valid = '0; wdata = '0; rdata_ready = 1'b0;
    spi_command_full = 1'b0; spi_read_dout = '0; spi_read_empty = 1'b1; done = 1'b0;
    cyc(); cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_len", spi_data_len, 8'd0);
    chk("rst_rvalid", rdata_valid, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_req_ready", req_ready, 2'b00);
    reset = 1'b0;

    // write from req0: addr 0x12, len 3, words A,B,C
    req_wnr = 2'b01; req_addr[9:0] = 10'h12; req_len[7:0] = 8'd3; req_opgrp[1:0] = 2'd1;
    req_valid = 2'b01;
    #1 chk("w_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    n0 = cmd_q.size();
    exp_q = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    for (int k = 0; k < 3; k++) begin
      wdata[31:0] = exp_q[k]; wdata_valid = 2'b01;
      #1 chk("w_wdata_ready", wdata_ready, 2'b01);
      chk("w_wr_en", spi_command_wr_en, 1'b1);
      cyc();
    end
    wdata_valid = 2'b00;
    chk("w_push_count", cmd_q.size() - n0, 3);
    for (int k = 0; k < 3; k++) if (n0 + k < cmd_q.size()) chk("w_push_data", cmd_q[n0+k], exp_q[k]);
    chk("w_run_len", spi_data_len, 8'd3);
    chk("w_run_addr", spi_address, 10'h12);
    chk("w_run_wnr", spi_wnr, 1'b1);
    chk("w_run_opgrp", spi_opcode_group, 2'd1);
    cyc();
    chk("w_run_len_held", spi_data_len, 8'd3);
    pulse_done();
    chk("w_busy_after_done", busy, 1'b0);
    chk("w_len_after_done", spi_data_len, 8'd0);

    // read from req1: len 2, FIFO holds X,Y
    exp_q = '{32'h1111_AAAA, 32'h2222_BBBB};
    preload(exp_q[0]); preload(exp_q[1]);
    req_wnr = 2'b00; req_addr[19:10] = 10'h155; req_len[15:8] = 8'd2; req_opgrp[3:2] = 2'd2;
    req_valid = 2'b10;
    #1 chk("r_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00;
    chk("r_run_len", spi_data_len, 8'd2);
    chk("r_run_wnr", spi_wnr, 1'b0);
    chk("r_run_addr", spi_address, 10'h155);
    pulse_done();
    chk("r_len_after_done", spi_data_len, 8'd0);
    rdata_ready = 1'b1;
    collect(20);
    check_read("r", 1'b1);
    chk("r_busy_end", busy, 1'b0);

    // contention: both held, len 1 writes, pointer starts at 0
    req_wnr = 2'b11; req_len = {8'd1, 8'd1};
    wdata = {32'h0000_1001, 32'h0000_1000};
    req_valid = 2'b11; wdata_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_grant = (t % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("c_grant", req_ready, exp_grant);
      cyc();
      chk("c_wdata_ready", wdata_ready, exp_grant);
      cyc();
      chk("c_run_len", spi_data_len, 8'd1);
      if (cmd_q.size() > 0) chk("c_push_word", cmd_q[cmd_q.size()-1], (t % 2 == 0) ? 32'h1000 : 32'h1001);
      pulse_done();
    end
    req_valid = 2'b00; wdata_valid = 2'b00;

    // command FIFO backpressure: req0 write len 4, full for 5 cycles after first word
    req_wnr = 2'b01; req_len[7:0] = 8'd4; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    n0 = cmd_q.size();
    exp_q = '{32'h0BAD_0000, 32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003};
    wdata[31:0] = exp_q[0]; wdata_valid = 2'b01;
    cyc();
    wdata[31:0] = exp_q[1]; spi_command_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_wdata_ready", wdata_ready, 2'b00);
      chk("bp_wr_en", spi_command_wr_en, 1'b0);
      cyc();
    end
    spi_command_full = 1'b0;
    for (int k = 1; k < 4; k++) begin
      wdata[31:0] = exp_q[k];
      cyc();
    end
    wdata_valid = 2'b00;
    chk("bp_push_count", cmd_q.size() - n0, 4);
    for (int k = 0; k < 4; k++) if (n0 + k < cmd_q.size()) chk("bp_push_data", cmd_q[n0+k], exp_q[k]);
    chk("bp_run_len", spi_data_len, 8'd4);
    pulse_done();

    // read backpressure: req1 read len 3, rdata_ready low 4 cycles
    exp_q = '{32'h5050_0001, 32'h5050_0002, 32'h5050_0003};
    for (int k = 0; k < 3; k++) preload(exp_q[k]);
    req_wnr = 2'b00; req_len[15:8] = 8'd3; req_valid = 2'b10;
    rdata_ready = 1'b0;
    cyc();
    req_valid = 2'b00;
    p0 = pops;
    pulse_done();
    for (int c = 0; c < 10; c++) begin
      if (rdata_valid) break;
      cyc();
    end
    chk("rbp_valid", rdata_valid, 1'b1);
    first_word = rdata;
    chk("rbp_first", first_word, exp_q[0]);
    for (int c = 0; c < 4; c++) begin
      chk("rbp_stable", rdata, exp_q[0]);
      chk("rbp_pops", pops - p0, 1);
      cyc();
    end
    rdata_ready = 1'b1;
    collect(30);
    check_read("rbp", 1'b1);
    chk("rbp_total_pops", pops - p0, 3);

    // timeout: req0 read len 1, done never comes
    req_wnr = 2'b00; req_len[7:0] = 8'd1; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    p0 = pops;
    run_cycles = 0; seen_err = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (err_timeout) begin
        seen_err = 1'b1;
        break;
      end
      if (spi_data_len != 8'd0) run_cycles++;
      cyc();
    end
    chk("to_seen", seen_err, 1'b1);
    chk("to_run_cycles", run_cycles, 16);
    chk("to_len", spi_data_len, 8'd0);
    chk("to_busy", busy, 1'b0);
    chk("to_rvalid", rdata_valid, 1'b0);
    cyc();
    chk("to_pulse_end", err_timeout, 1'b0);
    chk("to_no_pops", pops - p0, 0);

    // next request after timeout: req1 write len 1
    req_wnr = 2'b10; req_len[15:8] = 8'd1; wdata[63:32] = 32'h7777_0001; req_valid = 2'b10;
    #1 chk("post_to_grant", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00; wdata_valid = 2'b10;
    n0 = cmd_q.size();
    cyc();
    wdata_valid = 2'b00;
    chk("post_to_len", spi_data_len, 8'd1);
    if (cmd_q.size() > n0) chk("post_to_word", cmd_q[n0], 32'h7777_0001);
    pulse_done();
    chk("post_to_busy", busy, 1'b0);

    // zero length: req0 write len 0
    req_wnr = 2'b01; req_len[7:0] = 8'd0; req_valid = 2'b01;
    n0 = cmd_q.size(); p0 = pops;
    #1 chk("z_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    chk("z_busy", busy, 1'b0);
    cyc();
    chk("z_busy2", busy, 1'b0);
    chk("z_len", spi_data_len, 8'd0);
    chk("z_no_push", cmd_q.size() - n0, 0);
    chk("z_no_pop", pops - p0, 0);

    // max length: req1 write len 255
    req_wnr = 2'b10; req_len[15:8] = 8'd255; req_valid = 2'b10;
    #1 chk("m_grant", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00; wdata_valid = 2'b10;
    n0 = cmd_q.size();
    for (int k = 0; k < 255; k++) begin
      wdata[63:32] = 32'h00AB_0000 + k;
      cyc();
    end
    wdata_valid = 2'b00;
    chk("m_push_count", cmd_q.size() - n0, 255);
    if (cmd_q.size() > 0) chk("m_last_word", cmd_q[cmd_q.size()-1], 32'h00AB_00FE);
    chk("m_run_len", spi_data_len, 8'hFF);
    pulse_done();
    chk("m_busy", busy, 1'b0);

    // reset in RUN: req0 read len 2, pointer then moves to 1
    req_wnr = 2'b00; req_addr[9:0] = 10'h3A; req_len[7:0] = 8'd2; req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    chk("rr_run_len", spi_data_len, 8'd2);
    reset = 1'b1;
    cyc();
    chk("rr_len", spi_data_len, 8'd0);
    chk("rr_busy", busy, 1'b0);
    chk("rr_addr", spi_address, 10'h0);
    chk("rr_state", dbg_state, 2'd0);
    reset = 1'b0;
    req_len = '0; req_valid = 2'b11;
    #1 chk("rr_ptr_zero", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
